bin2bcd_seq: RTL and testbench

- Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble); the next generation of the fixed 16-bit Hex2Dec converter.
- Adds generic binary width and digit count, a start/busy/done handshake, overflow detection with saturation, and a leading-zero blanking mask.
- Sits between binary counters/ALU results and the 7-segment display drivers on the lab board.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_adj_row.sv | 21 ++
 rtl/bin2bcd_seq.sv | 148 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and helpers for the sequential binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Double-dabble pre-shift correction: digits of 5 or more would exceed 9 after doubling.
    function automatic logic [3:0] digit_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_adj_row.sv
`default_nettype none
// ============================================================================
// Module   : bcd_adj_row
// Brief    : Combinational add-3 correction applied to every digit of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_adj_row
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] i_acc,
    output logic [4*DIGITS-1:0] o_acc
);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign o_acc[4*i +: 4] = digit_adj(i_acc[4*i +: 4]);
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter with handshake,
//            overflow saturation and leading-zero blanking mask.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CE,
    input  logic                start,
    input  logic [BIN_W-1:0]    din,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int                    c_cnt_w  = $clog2(BIN_W + 1);
    localparam int                    c_acc_w  = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0]    c_last   = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0]    c_one    = c_cnt_w'(1);
    localparam logic [c_acc_w-1:0]    c_nines  = {DIGITS{BCD_NINE}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_finish;

    logic [BIN_W-1:0]     r_sr;
    logic [c_acc_w-1:0]   r_acc;
    logic                 r_sticky;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_acc_w-1:0]   r_bcd;
    logic                 r_ovf;

    logic [c_acc_w-1:0]         w_adj;
    logic [c_acc_w+BIN_W-1:0]   w_cat_sh;
    logic [c_acc_w-1:0]         w_acc_nxt;
    logic [BIN_W-1:0]           w_sr_nxt;
    logic                       w_out_bit;
    logic                       w_ovf;

    bcd_adj_row #(
        .DIGITS (DIGITS)
    ) u_adj_row (
        .i_acc (r_acc),
        .o_acc (w_adj)
    );

    // Bit leaving the top of the corrected accumulator is a lost 10^DIGITS contribution.
    assign w_cat_sh  = {w_adj, r_sr} << 1;
    assign w_acc_nxt = w_cat_sh[c_acc_w+BIN_W-1:BIN_W];
    assign w_sr_nxt  = w_cat_sh[BIN_W-1:0];
    assign w_out_bit = w_adj[c_acc_w-1];
    assign w_ovf     = r_sticky | w_out_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (CE) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == c_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
        end else if (CE) begin
            r_done <= w_finish;
            if (w_load) begin
                r_sr     <= din;
                r_acc    <= '0;
                r_sticky <= 1'b0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end
            if (w_shift) begin
                r_acc    <= w_acc_nxt;
                r_sr     <= w_sr_nxt;
                r_sticky <= w_ovf;
                r_cnt    <= r_cnt + c_one;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                r_ovf  <= w_ovf;
                r_bcd  <= w_ovf ? c_nines : w_acc_nxt;
            end
        end
    end

    // Digit 0 is always shown; an overflowed result shows every digit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = ~r_ovf & (r_bcd[c_acc_w-1:4*i] == '0);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Directed self-checking bench for bin2bcd_seq (5-digit and 4-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        ce5, start5;
    logic [15:0] din5;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  blank5;

    logic        ce4, start4;
    logic [15:0] din4;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut5 (
        .clk(clk), .rst(rst), .CE(ce5), .start(start5), .din(din5),
        .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5), .blank(blank5)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .CE(ce4), .start(start4), .din(din4),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4), .blank(blank4)
    );

    // Pulse start for one edge, then count negedges until done (100 = timed out).
    task automatic run5(input logic [15:0] d, output int cyc);
        start5 = 1'b1;
        din5   = d;
        @(negedge clk);
        start5 = 1'b0;
        cyc    = 1;
        while (!done5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run4(input logic [15:0] d, output int cyc);
        start4 = 1'b1;
        din4   = d;
        @(negedge clk);
        start4 = 1'b0;
        cyc    = 1;
        while (!done4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy5 !== 1'b0)      begin n_errors++; $display("FAIL reset_busy got %b want 0", busy5); end
        n_checks++; if (done5 !== 1'b0)      begin n_errors++; $display("FAIL reset_done got %b want 0", done5); end
        n_checks++; if (bcd5 !== 20'h00000)  begin n_errors++; $display("FAIL reset_bcd got %h want 00000", bcd5); end
        n_checks++; if (ovf5 !== 1'b0)       begin n_errors++; $display("FAIL reset_ovf got %b want 0", ovf5); end
        n_checks++; if (blank5 !== 5'b11110) begin n_errors++; $display("FAIL reset_blank5 got %b want 11110", blank5); end
        n_checks++; if (blank4 !== 4'b1110)  begin n_errors++; $display("FAIL reset_blank4 got %b want 1110", blank4); end
    endtask

    task automatic test_convert();
        int cyc;
        run5(16'h0001, cyc);
        n_checks++; if (cyc != 17)           begin n_errors++; $display("FAIL lat_1 got %0d want 17", cyc); end
        n_checks++; if (bcd5 !== 20'h00001)  begin n_errors++; $display("FAIL bcd_1 got %h want 00001", bcd5); end
        n_checks++; if (ovf5 !== 1'b0)       begin n_errors++; $display("FAIL ovf_1 got %b want 0", ovf5); end
        n_checks++; if (blank5 !== 5'b11110) begin n_errors++; $display("FAIL blank_1 got %b want 11110", blank5); end
        @(negedge clk);
        n_checks++; if (done5 !== 1'b0)      begin n_errors++; $display("FAIL done_pulse got %b want 0", done5); end

        run5(16'h00AA, cyc);
        n_checks++; if (bcd5 !== 20'h00170)  begin n_errors++; $display("FAIL bcd_170 got %h want 00170", bcd5); end
        n_checks++; if (blank5 !== 5'b11000) begin n_errors++; $display("FAIL blank_170 got %b want 11000", blank5); end
        n_checks++; if (busy5 !== 1'b0)      begin n_errors++; $display("FAIL busy_170 got %b want 0", busy5); end

        run5(16'hFFFF, cyc);
        n_checks++; if (bcd5 !== 20'h65535)  begin n_errors++; $display("FAIL bcd_65535 got %h want 65535", bcd5); end
        n_checks++; if (blank5 !== 5'b00000) begin n_errors++; $display("FAIL blank_65535 got %b want 00000", blank5); end
        n_checks++; if (ovf5 !== 1'b0)       begin n_errors++; $display("FAIL ovf_65535 got %b want 0", ovf5); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int cyc;
        run4(16'h2710, cyc);
        n_checks++; if (cyc != 17)          begin n_errors++; $display("FAIL lat_10000 got %0d want 17", cyc); end
        n_checks++; if (ovf4 !== 1'b1)      begin n_errors++; $display("FAIL ovf_10000 got %b want 1", ovf4); end
        n_checks++; if (bcd4 !== 16'h9999)  begin n_errors++; $display("FAIL bcd_10000 got %h want 9999", bcd4); end
        n_checks++; if (blank4 !== 4'b0000) begin n_errors++; $display("FAIL blank_10000 got %b want 0000", blank4); end
        run4(16'h270F, cyc);
        n_checks++; if (ovf4 !== 1'b0)      begin n_errors++; $display("FAIL ovf_9999 got %b want 0", ovf4); end
        n_checks++; if (bcd4 !== 16'h9999)  begin n_errors++; $display("FAIL bcd_9999 got %h want 9999", bcd4); end
        @(negedge clk);
    endtask

    task automatic test_ce_gating();
        int cyc;
        // First edge has CE=0; CE then alternates, start stays high into the busy period.
        start5 = 1'b1;
        din5   = 16'h001A;
        ce5    = 1'b0;
        cyc    = 0;
        while (!done5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            ce5 = ~ce5;
            if (cyc == 2)  din5 = 16'hFFFF;
            if (cyc == 20) start5 = 1'b0;
        end
        n_checks++; if (cyc != 34)          begin n_errors++; $display("FAIL ce_latency got %0d want 34", cyc); end
        n_checks++; if (bcd5 !== 20'h00026) begin n_errors++; $display("FAIL ce_bcd got %h want 00026", bcd5); end
        n_checks++; if (ovf5 !== 1'b0)      begin n_errors++; $display("FAIL ce_ovf got %b want 0", ovf5); end
        @(negedge clk);
        n_checks++; if (done5 !== 1'b1)     begin n_errors++; $display("FAIL ce_done_hold got %b want 1", done5); end
        ce5 = 1'b1;
        @(negedge clk);
        n_checks++; if (done5 !== 1'b0)     begin n_errors++; $display("FAIL ce_done_clear got %b want 0", done5); end
        n_checks++; if (bcd5 !== 20'h00026) begin n_errors++; $display("FAIL ce_bcd_hold got %h want 00026", bcd5); end
    endtask

    task automatic test_rst_abort();
        int cyc;
        int seen;
        start5 = 1'b1;
        din5   = 16'h1234;
        @(negedge clk);
        start5 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy5 !== 1'b0)     begin n_errors++; $display("FAIL abort_busy got %b want 0", busy5); end
        n_checks++; if (bcd5 !== 20'h00000) begin n_errors++; $display("FAIL abort_bcd got %h want 00000", bcd5); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done5) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen != 0)          begin n_errors++; $display("FAIL abort_done got %0d pulses want 0", seen); end
        run5(16'h0009, cyc);
        n_checks++; if (cyc != 17)          begin n_errors++; $display("FAIL after_abort_lat got %0d want 17", cyc); end
        n_checks++; if (bcd5 !== 20'h00009) begin n_errors++; $display("FAIL after_abort_bcd got %h want 00009", bcd5); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        start5 = 1'b1;
        din5   = 16'h0002;
        cyc    = 0;
        while (!done5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc != 17)          begin n_errors++; $display("FAIL b2b_lat0 got %0d want 17", cyc); end
        n_checks++; if (bcd5 !== 20'h00002) begin n_errors++; $display("FAIL b2b_bcd0 got %h want 00002", bcd5); end
        din5 = 16'h000A;
        cyc  = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done5 && cyc < 100);
        start5 = 1'b0;
        n_checks++; if (cyc != 17)          begin n_errors++; $display("FAIL b2b_lat1 got %0d want 17", cyc); end
        n_checks++; if (bcd5 !== 20'h00010) begin n_errors++; $display("FAIL b2b_bcd1 got %h want 00010", bcd5); end
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        ce5    = 1'b1;
        start5 = 1'b0;
        din5   = '0;
        ce4    = 1'b1;
        start4 = 1'b0;
        din4   = '0;
        @(negedge clk);
        test_reset();
        test_convert();
        test_overflow();
        test_ce_gating();
        test_rst_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
